aes_ctr_scheduler: RTL and testbench
====================================

Name: aes_ctr_scheduler

Overview:
- Sequences the iterative AES-256 encryption core in CTR mode.
- Builds counter blocks (nonce || 32-bit counter) and issues them to the core over a start/done handshake.
- Prefetches keystream into a small buffer and XORs it with the incoming data stream to produce ciphertext.
- Sits between the host data stream and the encryption core. The core's key expansion must be complete (key_ready) before any block is issued.

Parameters:
KS_DEPTH, 2, keystream buffer entries (1..4); in-flight core block counts against this limit.

Ports:
clk  input  1  clock
rst  input  1  reset; asynchronous, active-high
cfg_nonce  input  96  nonce; core_block[127:32]
cfg_ctr_init  input  32  initial counter; core_block[31:0]
cfg_load  input  1  pulse; in IDLE, load counters and enter RUN
cfg_resume  input  1  pulse; in IDLE, enter RUN keeping current counters
key_ready  input  1  round keys valid in core
core_ready  input  1  core idle, may accept core_start
core_start  output  1  one-cycle pulse issuing core_block
core_block  output  128  {nonce_q, issue_ctr}
core_done  input  1  one-cycle pulse; core_keystream valid
core_keystream  input  128  encrypted counter block
in_valid  input  1  data beat valid
in_ready  output  1  data beat accepted when in_valid&&in_ready
in_data  input  128  plaintext beat
in_last  input  1  final beat of message
out_valid  output  1  ciphertext valid
out_ready  input  1  downstream accepts
out_data  output  128  in_data ^ keystream
out_last  output  1  copy of in_last for that beat
busy  output  1  state != IDLE
err_wrap  output  1  sticky; counter exhausted

Behaviour:
- Reset values: all outputs 0. State IDLE. issue_ctr = consume_ctr = 0, nonce_q = 0. Buffer empty, inflight = 0, err_wrap = 0.
- State IDLE:
  - cfg_load: nonce_q <= cfg_nonce; issue_ctr <= consume_ctr <= cfg_ctr_init; err_wrap <= 0; next state RUN.
  - cfg_resume: next state RUN, counters unchanged.
  - cfg_load and cfg_resume together: cfg_load wins.
  - In any state other than IDLE, cfg_load and cfg_resume are ignored.
- State RUN, issue rule: core_start is asserted for one cycle when all of the following hold:
  - key_ready && core_ready && !inflight && !err_wrap
  - (ks_count + inflight) < KS_DEPTH
  - On the issue cycle: core_block = {nonce_q, issue_ctr}; inflight <= 1; issue_ctr <= issue_ctr + 1 (mod 2^32).
- Counter exhaustion: issuing with issue_ctr == 32'hFFFF_FFFF sets err_wrap. No further issue occurs until cfg_load.
- core_done with inflight = 1: push core_keystream into the buffer; inflight <= 0. core_done with inflight = 0 is ignored.
- Issue cadence: at most one block in flight, so the earliest re-issue is the cycle after core_done.
- Data path:
  - in_ready = (state == RUN) && ks_count > 0 && (!out_valid || out_ready). It depends combinationally on out_ready.
  - On accept: out_data <= in_data ^ buffer head; out_last <= in_last; out_valid <= 1; pop the buffer; consume_ctr <= consume_ctr + 1.
  - Latency is 1 cycle from accept to out_valid.
  - out_valid, out_data and out_last are held stable until out_ready. Full throughput is 1 beat/cycle while keystream is available.
- Simultaneous push and pop: allowed; ks_count is unchanged. A buffer entry pushed in cycle N can be popped in cycle N+1, not in cycle N.
- in_last accepted: next state DRAIN. No new issue occurs from that cycle on.
- State DRAIN:
  - Wait until inflight = 0; a pending core_done is discarded.
  - Then flush the buffer, set issue_ctr <= consume_ctr, and go to IDLE.
  - Result: a later cfg_resume continues exactly at the first unused counter.
  - busy stays 1 until IDLE is reached. out_valid may still be pending in DRAIN or IDLE and completes normally.
- key_ready deasserted mid-RUN: issue stalls; buffered keystream is still consumed.
- Reset mid-operation: all state is cleared immediately and any in-flight result is forgotten. core_done arriving after reset is ignored.

Test Plan:
- Reset, then cfg_load with nonce 96'h0123..AB, ctr 32'h0000_0001, key_ready = 1, core done 20 cycles after start -> core_block values are {nonce, 1} then {nonce, 2}; issue stops with ks_count + inflight = 2.
- Stream 4 beats with in_data = 128'h0 through a model core (keystream = block ^ 128'hFF..) -> out_data equals the keystream for ctr 1..4, in order; out_last is set on beat 4 only.
- out_ready held 0 for 5 cycles with in_valid = 1 -> in_ready = 0; out_data stable; no buffer pop; no counter change.
- Message of 1 beat with 2 blocks prefetched -> DRAIN discards the extra keystream; after IDLE, cfg_resume issues ctr = 2 (not 3).
- cfg_load with ctr = 32'hFFFF_FFFE -> blocks FFFF_FFFE and FFFF_FFFF are issued; err_wrap = 1; no further core_start until cfg_load.
- Assert rst while inflight = 1, then release and pulse core_done -> buffer stays empty, out_valid = 0, busy = 0, no core_start.

Source files
------------

// File: rtl/aes_ctr_scheduler.sv
// CTR-mode sequencer for the iterative AES-256 core: issues counter blocks,
// buffers returned keystream and XORs it onto the host data stream.
module aes_ctr_scheduler #(
    parameter int unsigned KS_DEPTH = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [95:0]  cfg_nonce,
    input  logic [31:0]  cfg_ctr_init,
    input  logic         cfg_load,
    input  logic         cfg_resume,
    input  logic         key_ready,
    input  logic         core_ready,
    output logic         core_start,
    output logic [127:0] core_block,
    input  logic         core_done,
    input  logic [127:0] core_keystream,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_data,
    input  logic         in_last,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_data,
    output logic         out_last,
    output logic         busy,
    output logic         err_wrap
);
    localparam int unsigned MAX_DEPTH = 4;
    localparam int unsigned PTR_W     = 2;
    localparam int unsigned CNT_W     = 3;
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(KS_DEPTH - 1);
    localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(KS_DEPTH);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t            state_q, state_d;
    logic [95:0]       nonce_q;
    logic [31:0]       issue_ctr, consume_ctr;
    logic              inflight;
    logic [127:0]      ks_mem [MAX_DEPTH];
    logic [PTR_W-1:0]  wr_ptr, rd_ptr;
    logic [CNT_W-1:0]  ks_count;
    logic              issue, accept, push, load, flush;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
    endfunction

    assign busy       = (state_q != IDLE);
    assign core_start = issue;
    assign core_block = {nonce_q, issue_ctr};

    // Next state plus the per-cycle issue/accept/push/flush decisions
    always_comb begin
        state_d  = state_q;
        in_ready = 1'b0;
        accept   = 1'b0;
        issue    = 1'b0;
        push     = 1'b0;
        load     = 1'b0;
        flush    = 1'b0;
        case (state_q)
            IDLE: begin
                if (cfg_load) begin
                    load    = 1'b1;
                    state_d = RUN;
                end else if (cfg_resume) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                in_ready = (ks_count != '0) && (!out_valid || out_ready);
                accept   = in_valid && in_ready;
                push     = core_done && inflight;
                issue    = key_ready && core_ready && !inflight && !err_wrap &&
                           ((ks_count + CNT_W'(inflight)) < DEPTH_C) &&
                           !(accept && in_last);
                if (accept && in_last) state_d = DRAIN;
            end
            DRAIN: begin
                if (!inflight) begin
                    flush   = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Counters, in-flight tracking, keystream FIFO pointers and output register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            nonce_q     <= '0;
            issue_ctr   <= '0;
            consume_ctr <= '0;
            err_wrap    <= 1'b0;
            inflight    <= 1'b0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            ks_count    <= '0;
            out_valid   <= 1'b0;
            out_data    <= '0;
            out_last    <= 1'b0;
        end else begin
            if (load) begin
                nonce_q     <= cfg_nonce;
                issue_ctr   <= cfg_ctr_init;
                consume_ctr <= cfg_ctr_init;
                err_wrap    <= 1'b0;
            end
            if (issue) begin
                issue_ctr <= issue_ctr + 32'd1;
                if (issue_ctr == 32'hFFFF_FFFF) err_wrap <= 1'b1;
            end
            if (accept) consume_ctr <= consume_ctr + 32'd1;
            // Rewind so a later resume starts at the first unused counter
            if (flush)  issue_ctr <= consume_ctr;

            if (issue)          inflight <= 1'b1;
            else if (core_done) inflight <= 1'b0;

            if (flush) begin
                wr_ptr   <= '0;
                rd_ptr   <= '0;
                ks_count <= '0;
            end else begin
                if (push)   wr_ptr <= ptr_inc(wr_ptr);
                if (accept) rd_ptr <= ptr_inc(rd_ptr);
                case ({push, accept})
                    2'b10:   ks_count <= ks_count + CNT_W'(1);
                    2'b01:   ks_count <= ks_count - CNT_W'(1);
                    default: ks_count <= ks_count;
                endcase
            end

            if (accept) begin
                out_valid <= 1'b1;
                out_data  <= in_data ^ ks_mem[rd_ptr];
                out_last  <= in_last;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) ks_mem[wr_ptr] <= core_keystream;
    end

endmodule

// File: tb/tb_aes_ctr_scheduler.sv
// Bench for aes_ctr_scheduler: model AES core, scoreboard of expected
// ciphertext per counter, directed corner cases plus randomized messages.
`timescale 1ns/1ps
module tb_aes_ctr_scheduler;
    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [95:0]  cfg_nonce = '0;
    logic [31:0]  cfg_ctr_init = '0;
    logic         cfg_load = 1'b0, cfg_resume = 1'b0;
    logic         key_ready = 1'b0, core_ready = 1'b1;
    logic         core_start;
    logic [127:0] core_block;
    logic         core_done = 1'b0;
    logic [127:0] core_keystream = '0;
    logic         in_valid = 1'b0, in_ready;
    logic [127:0] in_data = '0;
    logic         in_last = 1'b0;
    logic         out_valid, out_ready = 1'b1;
    logic [127:0] out_data;
    logic         out_last, busy, err_wrap;

    always #5 clk = ~clk;

    aes_ctr_scheduler #(.KS_DEPTH(2)) dut (
        .clk(clk), .rst(rst), .cfg_nonce(cfg_nonce), .cfg_ctr_init(cfg_ctr_init),
        .cfg_load(cfg_load), .cfg_resume(cfg_resume), .key_ready(key_ready),
        .core_ready(core_ready), .core_start(core_start), .core_block(core_block),
        .core_done(core_done), .core_keystream(core_keystream), .in_valid(in_valid),
        .in_ready(in_ready), .in_data(in_data), .in_last(in_last), .out_valid(out_valid),
        .out_ready(out_ready), .out_data(out_data), .out_last(out_last), .busy(busy),
        .err_wrap(err_wrap)
    );

    int total = 0;
    int bad = 0;
    int n_issue = 0;
    int cm_lat = 20;
    bit key_rand = 1'b0;

    typedef struct packed { logic [127:0] data; logic last; } exp_t;
    exp_t        sb[$];
    logic [95:0] nonce_m = '0;
    logic [31:0] issue_m = '0, cons_m = '0;
    logic        err_m = 1'b0;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [127:0] model_ks(input logic [95:0] n, input logic [31:0] c);
        return {n, c} ^ {128{1'b1}};
    endfunction

    // Model AES core: fixed latency, keystream = block ^ all-ones; ignores rst
    bit           cm_fire;
    bit           cm_busy = 1'b0;
    int           cm_cnt = 0;
    logic [127:0] cm_next, cm_block;
    always begin
        @(negedge clk);
        cm_fire = core_start;
        cm_next = core_block;
        @(posedge clk); #1;
        core_done = 1'b0;
        if (cm_fire) begin
            cm_busy = 1'b1; cm_cnt = cm_lat; cm_block = cm_next; core_ready = 1'b0;
        end else if (cm_busy) begin
            if (cm_cnt <= 1) begin
                core_done = 1'b1; core_keystream = cm_block ^ {128{1'b1}};
                cm_busy = 1'b0; core_ready = 1'b1;
            end else begin
                cm_cnt--;
            end
        end
    end

    always @(posedge clk) begin
        #1;
        if (key_rand) key_ready = ($urandom_range(3) != 0);
    end

    // Reference model and scoreboard, sampled mid-cycle
    always @(negedge clk) begin
        if (rst) begin
            sb.delete();
            nonce_m = '0; issue_m = '0; cons_m = '0; err_m = 1'b0;
        end else begin
            check("err_wrap", 128'(err_wrap), 128'(err_m));
            if (out_valid) begin
                check("sb_nonempty", 128'(sb.size() != 0), 128'(1));
                if (sb.size() != 0) begin
                    check("out_data", out_data, sb[0].data);
                    check("out_last", 128'(out_last), 128'(sb[0].last));
                    if (out_ready) void'(sb.pop_front());
                end
            end
            if (in_valid && in_ready) begin
                sb.push_back('{data: in_data ^ model_ks(nonce_m, cons_m), last: in_last});
                cons_m = cons_m + 32'd1;
                if (in_last) issue_m = cons_m;
            end
            if (core_start) begin
                check("core_block", core_block, {nonce_m, issue_m});
                check("issue_gate", 128'(err_m), 128'(0));
                n_issue++;
                if (issue_m == 32'hFFFF_FFFF) err_m = 1'b1;
                issue_m = issue_m + 32'd1;
            end
            if (cfg_load && !busy) begin
                nonce_m = cfg_nonce; issue_m = cfg_ctr_init; cons_m = cfg_ctr_init; err_m = 1'b0;
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic pulse_load(input logic [95:0] n, input logic [31:0] c);
        cfg_nonce = n; cfg_ctr_init = c; cfg_load = 1'b1;
        tick(1);
        cfg_load = 1'b0;
    endtask

    task automatic pulse_resume();
        cfg_resume = 1'b1;
        tick(1);
        cfg_resume = 1'b0;
    endtask

    task automatic send_msg(input int n, input bit zero, input int bp);
        bit acc;
        int guard = 0;
        for (int b = 0; b < n; b++) begin
            in_valid = 1'b1;
            in_data  = zero ? '0 : {$urandom, $urandom, $urandom, $urandom};
            in_last  = (b == n - 1);
            acc = 1'b0;
            while (!acc && guard < 2000) begin
                out_ready = (int'($urandom_range(99)) >= bp);
                @(negedge clk);
                acc = in_ready;
                guard++;
                @(posedge clk); #1;
            end
        end
        in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b1;
        check("send_timeout", 128'(guard < 2000), 128'(1));
    endtask

    task automatic wait_idle();
        bit done = 1'b0;
        out_ready = 1'b1; in_valid = 1'b0;
        for (int i = 0; i < 500 && !done; i++) begin
            @(negedge clk);
            done = !busy && !out_valid;
            @(posedge clk); #1;
        end
        check("idle_timeout", 128'(done), 128'(1));
    endtask

    task automatic wait_issue(input int limit, output logic [127:0] blk, output bit seen);
        seen = 1'b0; blk = '0;
        for (int i = 0; i < limit && !seen; i++) begin
            @(negedge clk);
            if (core_start) begin seen = 1'b1; blk = core_block; end
            @(posedge clk); #1;
        end
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [127:0] blk, held;
        bit seen;
        int base;

        tick(3);
        @(negedge clk);
        check("rst_core_start", 128'(core_start), 128'(0));
        check("rst_core_block", core_block, 128'(0));
        check("rst_out_valid", 128'(out_valid), 128'(0));
        check("rst_busy", 128'(busy), 128'(0));
        check("rst_in_ready", 128'(in_ready), 128'(0));
        check("rst_err", 128'(err_wrap), 128'(0));
        @(posedge clk); #1;
        rst = 1'b0;
        tick(2);

        // Prefetch stops at two outstanding blocks
        key_ready = 1'b1; cm_lat = 20;
        base = n_issue;
        pulse_load(96'h0123_4567_89AB_0123_4567_89AB, 32'h0000_0001);
        tick(120);
        check("prefetch_limit", 128'(n_issue - base), 128'(2));

        // Zero plaintext exposes keystream for ctr 1..4
        send_msg(4, 1'b1, 0);
        wait_idle();
        check("busy_after_msg", 128'(busy), 128'(0));

        // Downstream stall: nothing accepted, output held
        pulse_resume();
        tick(60);
        in_valid = 1'b1; in_data = {$urandom, $urandom, $urandom, $urandom}; in_last = 1'b0;
        @(negedge clk);
        check("stall_first_accept", 128'(in_ready), 128'(1));
        @(posedge clk); #1;
        out_ready = 1'b0;
        in_data = {$urandom, $urandom, $urandom, $urandom}; in_last = 1'b1;
        held = out_data;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("stall_in_ready", 128'(in_ready), 128'(0));
            check("stall_hold", out_data, held);
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        @(negedge clk);
        check("stall_release", 128'(in_ready), 128'(1));
        @(posedge clk); #1;
        in_valid = 1'b0; in_last = 1'b0;
        wait_idle();

        // One-beat message discards the extra prefetched block
        cm_lat = 3;
        pulse_load({$urandom, $urandom, $urandom}, 32'h0000_0001);
        tick(30);
        send_msg(1, 1'b0, 0);
        wait_idle();
        pulse_resume();
        wait_issue(50, blk, seen);
        check("resume_seen", 128'(seen), 128'(1));
        check("resume_ctr", 128'(blk[31:0]), 128'(2));
        send_msg(1, 1'b0, 0);
        wait_idle();

        // Counter exhaustion
        base = n_issue;
        pulse_load({$urandom, $urandom, $urandom}, 32'hFFFF_FFFE);
        tick(40);
        check("wrap_issues", 128'(n_issue - base), 128'(2));
        check("wrap_err", 128'(err_wrap), 128'(1));
        send_msg(2, 1'b0, 30);
        wait_idle();
        base = n_issue;
        pulse_resume();
        tick(30);
        check("wrap_no_issue", 128'(n_issue - base), 128'(0));
        rst = 1'b1; tick(2); rst = 1'b0; tick(1);

        // Reset with a block in flight; late core_done must be ignored
        cm_lat = 20;
        pulse_load({$urandom, $urandom, $urandom}, 32'd100);
        wait_issue(20, blk, seen);
        check("rst_issue_seen", 128'(seen), 128'(1));
        tick(3);
        rst = 1'b1; tick(2); rst = 1'b0;
        base = n_issue;
        tick(30);
        check("post_rst_busy", 128'(busy), 128'(0));
        check("post_rst_out_valid", 128'(out_valid), 128'(0));
        check("post_rst_no_issue", 128'(n_issue - base), 128'(0));
        key_ready = 1'b0;
        pulse_resume();
        tick(3);
        check("post_rst_buf_empty", 128'(in_ready), 128'(0));
        check("post_rst_run", 128'(busy), 128'(1));
        rst = 1'b1; tick(2); rst = 1'b0; tick(1);
        key_ready = 1'b1;

        // Randomized messages with backpressure and key_ready toggling
        key_rand = 1'b1;
        for (int it = 0; it < 15; it++) begin
            cm_lat = int'($urandom_range(8, 1));
            if (it == 0 || $urandom_range(1) == 1)
                pulse_load({$urandom, $urandom, $urandom}, $urandom_range(32'hFFFF_FF00));
            else
                pulse_resume();
            send_msg(int'($urandom_range(6, 1)), 1'b0, int'($urandom_range(60)));
            wait_idle();
        end
        key_rand = 1'b0;
        key_ready = 1'b1;
        tick(5);
        check("sb_empty", 128'(sb.size()), 128'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
